// File: rtl/spw_tx_fifo_reader_if.sv
// spw_tx_fifo_reader_if: FIFO read port plus transmit stream bundle.
// Ports: fifo_dout/empty/rd_ack/rd_err/rd_en, tx_data/valid/ready.
//
// master : the reader (drives fifo_rd_en, tx_data, tx_valid)
// slave  : the environment (FIFO and transmit encoder side)

interface spw_tx_fifo_reader_if #(
    parameter int DWIDTH = 9
);
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_rd_ack;
    logic              fifo_rd_err;
    logic              fifo_rd_en;

    logic [DWIDTH-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  fifo_rd_ack,
        input  fifo_rd_err,
        output fifo_rd_en,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output fifo_rd_ack,
        output fifo_rd_err,
        input  fifo_rd_en,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/spw_tx_fifo_reader.sv
// spw_tx_fifo_reader: drains the SpaceWire TX FIFO into a 2-entry skid
// buffer and presents a valid/ready N-char stream to the encoder.
//
// Ports:
//   i_gclk          clock, rising edge
//   i_sinit         synchronous active-high reset
//   bus (master)    FIFO read port and tx_data/tx_valid/tx_ready stream
//   i_fct_in        one-cycle pulse per received FCT
//   o_credit        current credit (N-chars)
//   o_pkt_done      pulse the cycle after an EOP/EEP is accepted
//   o_credit_err    sticky: an FCT would have exceeded CREDIT_MAX
//   o_underrun_err  sticky: FIFO read error or missing read ack
//
// Build option: define SPW_TX_CREDIT_EN to enable credit-based flow
// control. Without it tx_valid only reflects buffer occupancy, FCTs
// are ignored and o_credit/o_credit_err read as zero.

module spw_tx_fifo_reader #(
    parameter int DWIDTH      = 9,
    parameter int CREDIT_MAX  = 56,
    parameter int CREDIT_STEP = 8
) (
    input  logic                        i_gclk,
    input  logic                        i_sinit,
    spw_tx_fifo_reader_if.master        bus,
    input  logic                        i_fct_in,
    output logic [5:0]                  o_credit,
    output logic                        o_pkt_done,
    output logic                        o_credit_err,
    output logic                        o_underrun_err
);

    localparam int LP_CTRL = DWIDTH - 1;

    // Skid buffer: r_buf0 is always the head entry.
    logic [DWIDTH-1:0] r_buf0;
    logic [DWIDTH-1:0] r_buf1;
    logic [1:0]        r_occ;
    logic              r_inflight;
    logic              r_pkt_done;
    logic              r_underrun_err;

    logic              w_has_data;
    logic              w_credit_ok;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_rd_en;
    logic              w_eop;
    logic              w_miss;
    logic [2:0]        w_level;
    logic [2:0]        w_limit;

    assign w_has_data = (r_occ != 2'd0);
    assign w_valid    = w_has_data & w_credit_ok;
    assign w_pop      = w_valid & bus.tx_ready;

    // Data is only taken when we actually asked for it; this also
    // drops a stale ack that lands right after reset.
    assign w_push = r_inflight & bus.fifo_rd_ack;
    assign w_miss = r_inflight & ~bus.fifo_rd_ack;

    // Entries held plus entries on their way must fit in two slots;
    // a pop this cycle frees one, which keeps reads back-to-back.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_limit = 3'd2 + {2'b00, w_pop};
    assign w_rd_en = ~bus.fifo_empty & ~i_sinit & (w_level < w_limit);

    assign w_eop = r_buf0[LP_CTRL]
                 & ((r_buf0[1:0] == 2'b01) | (r_buf0[1:0] == 2'b10));

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.tx_data    = r_buf0;
    assign bus.tx_valid   = w_valid;

    assign o_pkt_done     = r_pkt_done;
    assign o_underrun_err = r_underrun_err;

    always_ff @(posedge i_gclk) begin
        if (i_sinit) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= bus.fifo_dout;
                    end else begin
                        r_buf1 <= bus.fifo_dout;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: head leaves, new tail lands.
                    if (r_occ == 2'd1) begin
                        r_buf0 <= bus.fifo_dout;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= bus.fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_gclk) begin
        if (i_sinit) begin
            r_inflight     <= 1'b0;
            r_pkt_done     <= 1'b0;
            r_underrun_err <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_pkt_done <= w_pop & w_eop;
            if (w_miss | bus.fifo_rd_err) begin
                r_underrun_err <= 1'b1;
            end
        end
    end

`ifdef SPW_TX_CREDIT_EN
    localparam logic [5:0] LP_STEP      = 6'(CREDIT_STEP);
    localparam logic [5:0] LP_STEP_M1   = 6'(CREDIT_STEP - 1);
    localparam logic [5:0] LP_FCT_LIMIT = 6'(CREDIT_MAX - CREDIT_STEP);

    logic [5:0] r_credit;
    logic       r_credit_err;
    logic       w_fct_ok;
    logic       w_fct_drop;

    // A grant that would push credit past the ceiling is discarded.
    assign w_fct_ok    = i_fct_in & (r_credit <= LP_FCT_LIMIT);
    assign w_fct_drop  = i_fct_in & ~w_fct_ok;
    assign w_credit_ok = (r_credit != 6'd0);

    always_ff @(posedge i_gclk) begin
        if (i_sinit) begin
            r_credit     <= 6'd0;
            r_credit_err <= 1'b0;
        end else begin
            case ({w_fct_ok, w_pop})
                2'b10:   r_credit <= r_credit + LP_STEP;
                2'b01:   r_credit <= r_credit - 6'd1;
                2'b11:   r_credit <= r_credit + LP_STEP_M1;
                default: r_credit <= r_credit;
            endcase
            if (w_fct_drop) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign o_credit     = r_credit;
    assign o_credit_err = r_credit_err;
`else
    logic w_unused_cfg;

    assign w_credit_ok  = 1'b1;
    assign o_credit     = 6'd0;
    assign o_credit_err = 1'b0;
    assign w_unused_cfg = i_fct_in ^ (CREDIT_MAX > CREDIT_STEP);
`endif

endmodule

// File: tb/tb_spw_tx_fifo_reader.sv
// tb_spw_tx_fifo_reader: randomized bench with a queue-based model of
// the reader, plus directed scenarios with hand-computed expectations.

module tb_spw_tx_fifo_reader;

`ifdef SPW_TX_CREDIT_EN
    localparam int CREDIT_ON = 1;
`else
    localparam int CREDIT_ON = 0;
`endif

    logic       clk;
    logic       sinit;
    logic       fct;
    logic [5:0] credit;
    logic       pkt_done;
    logic       credit_err;
    logic       underrun_err;

    spw_tx_fifo_reader_if #(.DWIDTH(9)) bus ();

    spw_tx_fifo_reader dut (
        .i_gclk         (clk),
        .i_sinit        (sinit),
        .bus            (bus.master),
        .i_fct_in       (fct),
        .o_credit       (credit),
        .o_pkt_done     (pkt_done),
        .o_credit_err   (credit_err),
        .o_underrun_err (underrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int is_eop(input int c);
        return ((c >= 256) && ((c % 4 == 1) || (c % 4 == 2))) ? 1 : 0;
    endfunction

    // FIFO emulation
    logic [8:0] fifo_q[$];
    logic [8:0] pend_data;
    int         rd_pend = 0;

    // Behavioural model state
    int mq[$];
    int minf   = 0;
    int mcred  = 0;
    int mpkt   = 0;
    int mcerr  = 0;
    int muerr  = 0;
    int mzero  = 0;
    int chk_on = 0;

    // Observation logs
    int pop_log[$];
    int pop_cyc[$];
    int n_pkt    = 0;
    int pkt_cyc  = 0;
    int cyc_n    = 0;
    int n_pop    = 0;
    int pv_stall = 0;
    int pv_data  = 0;

    always @(negedge clk) begin
        int ev, ep, er, n;
        #2;
        cyc_n++;
        if (chk_on != 0) begin
            n  = mq.size();
            ev = (n > 0 && (CREDIT_ON == 0 || mcred > 0)) ? 1 : 0;
            ep = (ev != 0 && bus.tx_ready === 1'b1) ? 1 : 0;
            er = (bus.fifo_empty === 1'b0 && sinit === 1'b0
                  && (n + minf < 2 + ep)) ? 1 : 0;

            chk("rd_en", 32'(bus.fifo_rd_en), 32'(er));
            chk("tx_valid", 32'(bus.tx_valid), 32'(ev));
            if (ev != 0) chk("tx_data", 32'(bus.tx_data), 32'(mq[0]));
            if (mzero != 0) chk("tx_data_rst", 32'(bus.tx_data), 32'(0));
            chk("credit", 32'(credit), 32'(mcred));
            chk("pkt_done", 32'(pkt_done), 32'(mpkt));
            chk("credit_err", 32'(credit_err), 32'(mcerr));
            chk("underrun_err", 32'(underrun_err), 32'(muerr));
            if (pv_stall != 0) begin
                chk("stall_valid", 32'(bus.tx_valid), 32'(1));
                chk("stall_data", 32'(bus.tx_data), 32'(pv_data));
            end

            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
                pop_log.push_back(int'(bus.tx_data));
                pop_cyc.push_back(cyc_n);
                n_pop++;
            end
            if (pkt_done === 1'b1) begin
                n_pkt++;
                pkt_cyc = cyc_n;
            end
            pv_stall = (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b0
                        && sinit === 1'b0) ? 1 : 0;
            pv_data  = int'(bus.tx_data);

            mzero = 0;
            if (sinit === 1'b1) begin
                mq.delete();
                minf  = 0;
                mcred = 0;
                mpkt  = 0;
                mcerr = 0;
                muerr = 0;
                mzero = 1;
            end else begin
                mpkt = (ep != 0) ? is_eop(mq[0]) : 0;
                if (ep != 0) void'(mq.pop_front());
                if (minf != 0 && bus.fifo_rd_ack === 1'b1)
                    mq.push_back(int'(bus.fifo_dout));
                if ((minf != 0 && bus.fifo_rd_ack === 1'b0)
                    || bus.fifo_rd_err === 1'b1)
                    muerr = 1;
                if (CREDIT_ON != 0 && fct === 1'b1) begin
                    if (mcred + 8 > 56) mcerr = 1;
                    else mcred += 8;
                end
                if (CREDIT_ON != 0 && ep != 0) mcred -= 1;
                minf = er;
            end
        end
    end

    task automatic cyc(input bit rdy, input bit f, input bit err,
                       input bit rst, input bit miss, input bit spur);
        @(negedge clk);
        if (spur) begin
            bus.fifo_rd_ack = 1'b1;
            bus.fifo_dout   = 9'h1AA;
        end else if (rd_pend != 0) begin
            bus.fifo_rd_ack = 1'b1;
            bus.fifo_dout   = pend_data;
        end else begin
            bus.fifo_rd_ack = 1'b0;
            bus.fifo_dout   = 9'($urandom);
        end
        bus.fifo_empty  = (fifo_q.size() == 0);
        bus.fifo_rd_err = err;
        bus.tx_ready    = rdy;
        fct             = f;
        sinit           = rst;
        #3;
        rd_pend = 0;
        if (bus.fifo_rd_en === 1'b1 && fifo_q.size() > 0 && !miss) begin
            pend_data = fifo_q.pop_front();
            rd_pend   = 1;
        end
    endtask

    task automatic do_reset();
        fifo_q.delete();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit rdy, input int k);
        for (int i = 0; i < k; i++)
            cyc(rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int base;
        sinit           = 1'b1;
        fct             = 1'b0;
        bus.fifo_dout   = '0;
        bus.fifo_empty  = 1'b1;
        bus.fifo_rd_ack = 1'b0;
        bus.fifo_rd_err = 1'b0;
        bus.tx_ready    = 1'b0;

        // Reset values
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_on = 1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", 32'(bus.tx_valid), 32'(0));
        chk("rst_data", 32'(bus.tx_data), 32'(0));
        chk("rst_credit", 32'(credit), 32'(0));
        chk("rst_uerr", 32'(underrun_err), 32'(0));

        // Three N-chars, one FCT, encoder always ready
        pop_log.delete();
        pop_cyc.delete();
        n_pkt = 0;
        fifo_q.push_back(9'h041);
        fifo_q.push_back(9'h042);
        fifo_q.push_back(9'h101);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 7);
        chk("seq_len", 32'(pop_log.size()), 32'(3));
        if (pop_log.size() == 3) begin
            chk("seq0", 32'(pop_log[0]), 32'h041);
            chk("seq1", 32'(pop_log[1]), 32'h042);
            chk("seq2", 32'(pop_log[2]), 32'h101);
            chk("seq_span", 32'(pop_cyc[2] - pop_cyc[0]), 32'(2));
            chk("pkt_when", 32'(pkt_cyc - pop_cyc[2]), 32'(1));
        end
        chk("pkt_count", 32'(n_pkt), 32'(1));
        chk("credit_end", 32'(credit), 32'(CREDIT_ON * 5));

        // Zero credit with the buffer full, then one FCT
        do_reset();
        for (int i = 0; i < 4; i++) fifo_q.push_back(9'(i + 3));
        idle(1'b1, 7);
        chk("c0_valid", 32'(bus.tx_valid), 32'(0));
        chk("c0_rd_en", 32'(bus.fifo_rd_en), 32'(0));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("c0_fct_valid", 32'(bus.tx_valid), 32'(CREDIT_ON));
        chk("c0_fct_credit", 32'(credit), 32'(CREDIT_ON * 8));
        idle(1'b1, 6);

        // Credit ceiling
        do_reset();
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cap_credit", 32'(credit), 32'(CREDIT_ON * 56));
        chk("cap_err", 32'(credit_err), 32'(CREDIT_ON));
        idle(1'b0, 5);
        chk("cap_sticky", 32'(credit_err), 32'(CREDIT_ON));
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cap_clear", 32'(credit_err), 32'(0));

        // Toggling ready, 10 entries, credit 16
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        base = n_pop;
        for (int i = 0; i < 10; i++) fifo_q.push_back(9'(8'h80 + i));
        for (int i = 0; i < 40; i++)
            cyc(i % 2 == 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("toggle_pops", 32'(n_pop - base), 32'(10));

        // Missing ack, then read error pulse
        do_reset();
        fifo_q.push_back(9'h011);
        fifo_q.push_back(9'h012);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("miss_uerr", 32'(underrun_err), 32'(1));
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rderr_uerr", 32'(underrun_err), 32'(1));

        // Reset with a read in flight, then a stray ack
        do_reset();
        for (int i = 0; i < 3; i++) fifo_q.push_back(9'(9'h050 + i));
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        fifo_q.delete();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_valid", 32'(bus.tx_valid), 32'(0));
        chk("mid_data", 32'(bus.tx_data), 32'(0));
        chk("mid_credit", 32'(credit), 32'(0));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stale_valid", 32'(bus.tx_valid), 32'(0));
        chk("stale_uerr", 32'(underrun_err), 32'(0));

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int k;
            logic [8:0] d;
            if (fifo_q.size() < 16) begin
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++) begin
                    d = 9'($urandom_range(0, 255));
                    if ($urandom_range(0, 5) == 0)
                        d = 9'h100 | 9'($urandom_range(0, 3));
                    fifo_q.push_back(d);
                end
            end
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 199) == 0,
                $urandom_range(0, 299) == 0,
                $urandom_range(0, 99) == 0,
                1'b0);
        end
        idle(1'b1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
